// File: rtl/hls_cnn_2d_100s_sdiv_27s_12s_16_seq.sv
// Sequential signed divider: restoring shift-subtract on operand magnitudes,
// one quotient bit per cycle, followed by sign fix-up and quotient saturation.
// A single operation runs IDLE -> CALC (din0_WIDTH cycles) -> FIX -> DONE.
module hls_cnn_2d_100s_sdiv_27s_12s_16_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 27,
    parameter int din1_WIDTH = 12,
    parameter int dout_WIDTH = 16
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic                         start,
    input  logic signed [din0_WIDTH-1:0] din0,
    input  logic signed [din1_WIDTH-1:0] din1,
    output logic                         ready,
    output logic                         done,
    output logic signed [dout_WIDTH-1:0] dout,
    output logic signed [din1_WIDTH-1:0] remd,
    output logic                         div_by_zero,
    output logic                         ovf
);

    localparam int CW = $clog2(din0_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(din0_WIDTH - 1);

    // Quotient bounds, expressed at the width of the signed internal quotient
    localparam logic signed [din0_WIDTH+1:0] QMAX_X =
        $signed({{(din0_WIDTH+3-dout_WIDTH){1'b0}}, {(dout_WIDTH-1){1'b1}}});
    localparam logic signed [din0_WIDTH+1:0] QMIN_X =
        $signed({{(din0_WIDTH+3-dout_WIDTH){1'b1}}, {(dout_WIDTH-1){1'b0}}});
    localparam logic signed [dout_WIDTH-1:0] DMAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
    localparam logic signed [dout_WIDTH-1:0] DMIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    function automatic logic q_ovf(input logic signed [din0_WIDTH+1:0] v);
        return (v > QMAX_X) || (v < QMIN_X);
    endfunction

    function automatic logic signed [dout_WIDTH-1:0] q_sat(input logic signed [din0_WIDTH+1:0] v);
        if (v > QMAX_X) return DMAX;
        if (v < QMIN_X) return DMIN;
        return dout_WIDTH'(v);
    endfunction

    state_t                         state_q, state_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [din0_WIDTH:0]            quo_q, quo_d;     // dividend shifts out, quotient shifts in
    logic [din1_WIDTH:0]            rem_q, rem_d;     // partial remainder magnitude
    logic [din1_WIDTH-1:0]          dmag_q, dmag_d;   // divisor magnitude
    logic                           qneg_q, qneg_d;   // quotient is negative
    logic                           rneg_q, rneg_d;   // dividend (and remainder) is negative
    logic                           dz_q, dz_d;       // divisor was zero
    logic [din1_WIDTH-1:0]          dzrem_q, dzrem_d; // truncated dividend for the /0 case
    logic signed [dout_WIDTH-1:0]   dout_q, dout_d;
    logic signed [din1_WIDTH-1:0]   remd_q, remd_d;
    logic                           dbz_q, dbz_d;
    logic                           ovf_q, ovf_d;

    logic [din1_WIDTH+1:0]          rem_sh;
    logic                           qbit;
    logic signed [din0_WIDTH+1:0]   qval;

    assign rem_sh = {rem_q, quo_q[din0_WIDTH-1]};
    assign qbit   = (rem_sh >= {2'b00, dmag_q});
    assign qval   = qneg_q ? -$signed({1'b0, quo_q}) : $signed({1'b0, quo_q});

    // Next-state, datapath step and result fix-up
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dmag_d  = dmag_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        dzrem_d = dzrem_q;
        dout_d  = dout_q;
        remd_d  = remd_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    quo_d   = {1'b0, (din0[din0_WIDTH-1] ? din0_WIDTH'(-din0) : din0_WIDTH'(din0))};
                    dmag_d  = din1[din1_WIDTH-1] ? din1_WIDTH'(-din1) : din1_WIDTH'(din1);
                    rem_d   = '0;
                    qneg_d  = din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
                    rneg_d  = din0[din0_WIDTH-1];
                    dz_d    = (din1 == '0);
                    dzrem_d = din0[din1_WIDTH-1:0];
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                quo_d = {1'b0, quo_q[din0_WIDTH-2:0], qbit};
                rem_d = qbit ? (din1_WIDTH+1)'(rem_sh - {2'b00, dmag_q}) : rem_sh[din1_WIDTH:0];
                cnt_d = CW'(cnt_q + 1'b1);
                if (cnt_q == LAST_BIT) state_d = S_FIX;
            end
            S_FIX: begin
                if (dz_q) begin
                    dout_d = rneg_q ? DMIN : DMAX;
                    remd_d = dzrem_q;
                    dbz_d  = 1'b1;
                    ovf_d  = 1'b0;
                end else begin
                    dout_d = q_sat(qval);
                    remd_d = din1_WIDTH'(rneg_q ? -rem_q : rem_q);
                    dbz_d  = 1'b0;
                    ovf_d  = q_ovf(qval);
                end
                state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state and registered results, cleared by reset
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dout_q  <= '0;
            remd_q  <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            remd_q  <= remd_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operand and working registers; always loaded before use, so no reset
    always_ff @(posedge ap_clk) begin
        quo_q   <= quo_d;
        rem_q   <= rem_d;
        dmag_q  <= dmag_d;
        qneg_q  <= qneg_d;
        rneg_q  <= rneg_d;
        dz_q    <= dz_d;
        dzrem_q <= dzrem_d;
    end

    assign ready       = (state_q == S_IDLE);
    assign done        = (state_q == S_DONE);
    assign dout        = dout_q;
    assign remd        = remd_q;
    assign div_by_zero = dbz_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_hls_cnn_2d_100s_sdiv_27s_12s_16_seq.sv
// Bench for the sequential signed divider: spec vector table, randomized
// operands against a plain-arithmetic model, and multi-cycle corner sequences.
module tb_hls_cnn_2d_100s_sdiv_27s_12s_16_seq;

    logic                ap_clk = 1'b0;
    logic                ap_rst;
    logic                start;
    logic signed [26:0]  din0;
    logic signed [11:0]  din1;
    logic                ready, done;
    logic signed [15:0]  dout;
    logic signed [11:0]  remd;
    logic                div_by_zero, ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    hls_cnn_2d_100s_sdiv_27s_12s_16_seq #(
        .ID(1), .din0_WIDTH(27), .din1_WIDTH(12), .dout_WIDTH(16)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .start(start),
        .din0(din0), .din1(din1),
        .ready(ready), .done(done), .dout(dout), .remd(remd),
        .div_by_zero(div_by_zero), .ovf(ovf)
    );

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    typedef struct {
        longint a;
        longint b;
        longint q;
        longint r;
        bit     dz;
        bit     ov;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: SV integer division truncates toward zero, % takes dividend sign
    function automatic void model(input longint a, input longint b,
                                  output longint q, output longint r,
                                  output bit dz, output bit ov);
        logic signed [11:0] t;
        longint qq;
        if (b == 0) begin
            dz = 1; ov = 0;
            q  = (a >= 0) ? 32767 : -32768;
            t  = a[11:0];
            r  = t;
        end else begin
            dz = 0;
            qq = a / b;
            r  = a % b;
            if (qq > 32767)       begin q = 32767;  ov = 1; end
            else if (qq < -32768) begin q = -32768; ov = 1; end
            else                  begin q = qq;     ov = 0; end
        end
    endfunction

    task automatic step();
        @(posedge ap_clk); #1;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!ready && n < 100) begin step(); n++; end
        chk({nm, "_ready"}, ready, 1);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 100) begin step(); lat++; end
    endtask

    // Present operands with start for exactly the sampling edge, then scramble inputs
    task automatic start_op(input longint a, input longint b);
        din0  = a[26:0];
        din1  = b[11:0];
        start = 1'b1;
        step();
        start = 1'b0;
        din0  = 27'($urandom);
        din1  = 12'($urandom);
    endtask

    task automatic check_res(input string nm, input longint q, input longint r,
                             input bit dz, input bit ov);
        chk({nm, "_dout"}, longint'(dout), q);
        chk({nm, "_remd"}, longint'(remd), r);
        chk({nm, "_dbz"}, div_by_zero, dz);
        chk({nm, "_ovf"}, ovf, ov);
    endtask

    task automatic run_op(input string nm, input longint a, input longint b,
                          input longint q, input longint r, input bit dz, input bit ov);
        int lat;
        wait_ready(nm);
        start_op(a, b);
        wait_done(lat);
        chk({nm, "_lat"}, lat, 28);
        check_res(nm, q, r, dz, ov);
        step();
        chk({nm, "_done_pulse"}, done, 0);
        chk({nm, "_hold"}, longint'(dout), q);
    endtask

    initial begin
        int lat, ndone;
        int dcyc[3];
        longint q, r, a, b;
        bit dz, ov;
        logic signed [26:0] ra;
        logic signed [11:0] rb;
        longint ha[3];
        longint hb[3];

        tbl[0] = '{1000, 7, 142, 6, 0, 0};
        tbl[1] = '{-1000, 7, -142, -6, 0, 0};
        tbl[2] = '{1000, -7, -142, 6, 0, 0};
        tbl[3] = '{100, 0, 32767, 100, 1, 0};
        tbl[4] = '{-5, 0, -32768, -5, 1, 0};
        tbl[5] = '{-67108864, -1, 32767, 0, 0, 1};
        tbl[6] = '{65536, 2, 32767, 0, 0, 1};
        tbl[7] = '{-65536, 2, -32768, 0, 0, 0};
        tbl[8] = '{0, 5, 0, 0, 0, 0};

        ap_rst = 1'b1; start = 1'b0; din0 = '0; din1 = '0;
        repeat (3) @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        check_res("rst", 0, 0, 0, 0);

        // Spec vectors
        for (int i = 0; i < 9; i++)
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b,
                   tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ov);

        // Randomized operands against the model
        for (int i = 0; i < 16; i++) begin
            ra = 27'($urandom);
            rb = 12'($urandom);
            case ($urandom_range(0, 3))
                0: a = longint'($urandom_range(0, 4000)) - 2000;
                default: a = ra;
            endcase
            case ($urandom_range(0, 4))
                0: b = longint'($urandom_range(1, 20)) * (($urandom_range(0, 1) == 1) ? -1 : 1);
                1: b = 0;
                default: b = rb;
            endcase
            model(a, b, q, r, dz, ov);
            run_op($sformatf("rnd%0d", i), a, b, q, r, dz, ov);
        end

        // Start while busy is ignored and not queued
        wait_ready("ign");
        start_op(1000, 7);
        repeat (4) step();
        din0 = 500; din1 = 3; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(lat);
        chk("ign_lat", lat + 5, 28);
        check_res("ign", 142, 6, 0, 0);
        ndone = 0;
        repeat (40) begin step(); if (done) ndone++; end
        chk("ign_noqueue", ndone, 0);
        chk("ign_hold", longint'(dout), 142);

        // Reset mid-operation aborts it
        wait_ready("abort");
        start_op(-1000, 7);
        repeat (9) step();
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
        chk("abort_done", done, 0);
        chk("abort_ready", ready, 1);
        check_res("abort", 0, 0, 0, 0);
        ndone = 0;
        repeat (40) begin step(); if (done) ndone++; end
        chk("abort_nodone", ndone, 0);

        // Start held high across three operations
        ha[0] = 1000;   hb[0] = 7;
        ha[1] = -30000; hb[1] = -123;
        ha[2] = 123456; hb[2] = -45;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_ready($sformatf("held%0d", k));
            din0 = ha[k][26:0];
            din1 = hb[k][11:0];
            step();
            chk($sformatf("held%0d_busy", k), ready, 0);
            wait_done(lat);
            chk($sformatf("held%0d_lat", k), lat, 28);
            dcyc[k] = cyc;
            model(ha[k], hb[k], q, r, dz, ov);
            check_res($sformatf("held%0d", k), q, r, dz, ov);
        end
        start = 1'b0;
        chk("held_gap1", dcyc[1] - dcyc[0], 30);
        chk("held_gap2", dcyc[2] - dcyc[1], 30);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hls_cnn_2d_100s_sdiv_27s_12s_16_seq.md
HLS_CNN_2D_100S_SDIV_27S_12S_16_SEQ -- requirements
Module: hls_cnn_2d_100s_sdiv_27s_12s_16_seq

Interface
REQ-001 Parameter ID, default 1, instance identifier; no functional effect.
REQ-002 Parameter din0_WIDTH, default 27, signed dividend width.
REQ-003 Parameter din1_WIDTH, default 12, signed divisor width.
REQ-004 Parameter dout_WIDTH, default 16, signed quotient width.
REQ-005 ap_clk  in  1  single clock; all state changes on the rising edge.
REQ-006 ap_rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  request; sampled only when ready=1.
REQ-008 din0  in  din0_WIDTH  signed dividend.
REQ-009 din1  in  din1_WIDTH  signed divisor.
REQ-010 ready  out  1  high only in IDLE; block accepts start.
REQ-011 done  out  1  one-cycle pulse; results valid.
REQ-012 dout  out  dout_WIDTH  signed quotient.
REQ-013 remd  out  din1_WIDTH  signed remainder.
REQ-014 div_by_zero  out  1  divisor was zero.
REQ-015 ovf  out  1  quotient saturated.

Function
REQ-016 States IDLE, CALC, FIX, DONE.
REQ-017 IDLE: start=1 latches din0/din1, their signs, and magnitudes; bit counter cleared; next state CALC.
REQ-018 CALC: restoring shift-subtract on magnitudes, one quotient bit per cycle, exactly din0_WIDTH cycles, then FIX.
REQ-019 Internal quotient magnitude held at din0_WIDTH+1 bits; partial remainder at din1_WIDTH+1 bits.
REQ-020 FIX: apply signs, saturate, register dout/remd/flags; next state DONE.
REQ-021 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-022 Latency: done visible din0_WIDTH+1 edges after the start-sampling edge (28 for defaults).
REQ-023 Quotient truncates toward zero; remainder takes dividend's sign; din0 = q*din1 + r when not saturated.
REQ-024 Quotient outside [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1]: clamp to nearest bound, ovf=1.
REQ-025 din1=0: dout = max positive if din0>=0, else min negative; remd=din0 truncated to din1_WIDTH; div_by_zero=1; ovf=0; latency unchanged.
REQ-026 start while ready=0 (CALC/FIX/DONE) ignored; no queuing.
REQ-027 dout, remd, div_by_zero, ovf hold from FIX until the next FIX; input changes after capture have no effect.
REQ-028 start held high: next operation accepted in the IDLE cycle following DONE (one-cycle gap).

Reset
REQ-029 ap_rst=1 at any edge forces IDLE; dout=0, remd=0, done=0, div_by_zero=0, ovf=0, counter=0.
REQ-030 ready=1 in the first cycle after ap_rst deasserts.
REQ-031 Reset during CALC/FIX/DONE aborts the operation; no done pulse is produced for it.

Verification
REQ-032 din0=1000, din1=7 -> dout=142, remd=6, flags 0, done exactly 28 edges after start.
REQ-033 din0=-1000, din1=7 -> dout=-142, remd=-6; din0=1000, din1=-7 -> dout=-142, remd=6.
REQ-034 din0=100, din1=0 -> dout=32767, remd=100, div_by_zero=1; din0=-5, din1=0 -> dout=-32768.
REQ-035 din0=-67108864, din1=-1 -> dout=32767, ovf=1; din0=65536, din1=2 -> dout=32767, ovf=1; din0=-65536, din1=2 -> dout=-32768, ovf=0.
REQ-036 Second start, different operands, 5 cycles after first -> ignored; first result unchanged; ap_rst pulse at cycle 10 of an operation -> no done, outputs 0, ready=1 next cycle.
REQ-037 start held high across three operations -> three done pulses, 30 cycles apart, each with correct result.
